// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler feeding a single UART tx path
// One frame at a time: grant, hold tx enable, wait for tx_done low-then-high, then idle gap.
module uart_tx_sched #(
    parameter int N_REQ         = 4,
    parameter int EN_HOLD       = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int FRAME_TIMEOUT = 32768
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_en_o,
    input  logic                 tx_done_i,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] WD_LAST  = 16'(FRAME_TIMEOUT - 1);
    localparam logic [2:0]  EN_LAST  = 3'(EN_HOLD - 1);
    localparam logic [2:0]  GAP_LAST = 3'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_ASSERT,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [15:0]        wd_q, wd_d;
    logic [2:0]         en_cnt_q, en_cnt_d;
    logic [2:0]         gap_cnt_q, gap_cnt_d;
    logic               seen_low_q, seen_low_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_en_q, tx_en_d;
    logic               timeout_q, timeout_d;

    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   win_next;
    logic [N_REQ-1:0]   win_onehot;

    // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
    always_comb begin
        logic found;
        found      = 1'b0;
        win        = '0;
        win_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        win_onehot[win] = 1'b1;
        win_next        = PTR_W'((int'(win) + 1) % N_REQ);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wd_d       = wd_q;
        en_cnt_d   = en_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        seen_low_d = seen_low_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        ready_d    = '0;
        tx_en_d    = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            S_FLUSH: begin
                // Let an in-flight frame finish; expiry here is silent.
                if (tx_done_i || wd_q == WD_LAST) begin
                    state_d = S_IDLE;
                    wd_d    = '0;
                end else if (wd_q != 16'hFFFF) begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_IDLE: begin
                if (|req_valid_i) begin
                    state_d    = S_ASSERT;
                    tx_data_d  = req_data_i[8*int'(win) +: 8];
                    grant_d    = win_onehot;
                    ready_d    = win_onehot;
                    ptr_d      = win_next;
                    wd_d       = '0;
                    en_cnt_d   = '0;
                    seen_low_d = 1'b0;
                    tx_en_d    = 1'b1;
                end
            end
            S_ASSERT: begin
                if (!tx_done_i) seen_low_d = 1'b1;
                if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else begin
                    if (wd_q != 16'hFFFF) wd_d = wd_q + 16'd1;
                    if (en_cnt_q == EN_LAST) begin
                        state_d = S_WAIT_DONE;
                    end else begin
                        if (en_cnt_q != 3'h7) en_cnt_d = en_cnt_q + 3'd1;
                        tx_en_d = 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!tx_done_i) seen_low_d = 1'b1;
                // A done level only counts once the tx path has been seen busy.
                if (seen_low_q && tx_done_i) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else if (wd_q != 16'hFFFF) begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else if (gap_cnt_q != 3'h7) begin
                    gap_cnt_d = gap_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = S_FLUSH;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_FLUSH;
            ptr_q      <= '0;
            wd_q       <= '0;
            en_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            seen_low_q <= 1'b0;
            grant_q    <= '0;
            ready_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_en_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wd_q       <= wd_d;
            en_cnt_q   <= en_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            seen_low_q <= seen_low_d;
            grant_q    <= grant_d;
            ready_q    <= ready_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            timeout_q  <= timeout_d;
        end
    end

    assign req_ready_o = ready_q;
    assign grant_o     = grant_q;
    assign tx_data_o   = tx_data_q;
    assign tx_en_o     = tx_en_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
// Watchdog limit is shortened so the long-frame and timeout scenarios stay brief.
module tb_uart_tx_sched;

    localparam int TO   = 1024;
    localparam int LONG = 1000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_ready_o;
    logic [3:0]  grant_o;
    logic [7:0]  tx_data_o;
    logic        tx_en_o;
    logic        tx_done_i;
    logic        busy_o;
    logic        timeout_o;

    int n_cmp = 0;
    int n_err = 0;
    int tmo_cnt = 0;
    int ready_cnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    uart_tx_sched #(
        .N_REQ(4),
        .EN_HOLD(4),
        .GAP_CYCLES(2),
        .FRAME_TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .grant_o(grant_o),
        .tx_data_o(tx_data_o),
        .tx_en_o(tx_en_o),
        .tx_done_i(tx_done_i),
        .busy_o(busy_o),
        .timeout_o(timeout_o)
    );

    always @(negedge clk) begin
        if (timeout_o === 1'b1) tmo_cnt++;
        for (int k = 0; k < 4; k++)
            if (req_ready_o[k] === 1'b1) ready_cnt[k]++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serve one frame whose capture happens on the first edge; done goes low then high.
    task automatic serve(input int k, input logic [7:0] b);
        logic [3:0] oh;
        int n;
        oh = 4'b0001 << k;
        tick();
        check("serve_grant", grant_o, oh);
        check("serve_ready", req_ready_o, oh);
        check("serve_data", tx_data_o, b);
        tx_done_i = 1'b0;
        tick();
        check("serve_ready_once", req_ready_o, 4'b0000);
        tick();
        tick();
        tick();
        check("serve_en_off", tx_en_o, 1'b0);
        tx_done_i = 1'b1;
        n = 0;
        while (busy_o && n < 20) begin
            tick();
            n++;
        end
        check("serve_gap_len", n, 3);
        check("serve_grant_clr", grant_o, 4'b0000);
    endtask

    initial begin
        int n;
        rst_i       = 1'b1;
        req_valid_i = 4'b0000;
        req_data_i  = {8'hD3, 8'hA5, 8'h5B, 8'h3C};
        tx_done_i   = 1'b1;

        // Reset values
        tick();
        tick();
        check("rst_busy", busy_o, 1'b1);
        check("rst_en", tx_en_o, 1'b0);
        check("rst_data", tx_data_o, 8'h00);
        check("rst_grant", grant_o, 4'b0000);
        check("rst_ready", req_ready_o, 4'b0000);
        check("rst_tmo", timeout_o, 1'b0);
        rst_i = 1'b0;

        // Flush with done high exits after one cycle
        tick();
        check("flush_fast", busy_o, 1'b0);

        // First frame from requester 2, long in-flight time, no timeout
        req_valid_i = 4'b0100;
        tick();
        check("f1_grant", grant_o, 4'b0100);
        check("f1_data", tx_data_o, 8'hA5);
        check("f1_ready", req_ready_o, 4'b0100);
        check("f1_en0", tx_en_o, 1'b1);
        req_valid_i = 4'b0000;
        tick();
        check("f1_ready_off", req_ready_o, 4'b0000);
        check("f1_en1", tx_en_o, 1'b1);
        tick();
        check("f1_en2", tx_en_o, 1'b1);
        tick();
        check("f1_en3", tx_en_o, 1'b1);
        tick();
        check("f1_en4_low", tx_en_o, 1'b0);
        check("f1_busy_wait", busy_o, 1'b1);
        tick();
        tx_done_i = 1'b0;
        repeat (LONG) tick();
        check("f1_grant_hold", grant_o, 4'b0100);
        tx_done_i = 1'b1;
        n = 0;
        while (busy_o && n < 20) begin
            tick();
            n++;
            if (n == 2) check("f1_data_in_gap", tx_data_o, 8'hA5);
        end
        check("f1_gap_len", n, 3);
        check("f1_no_tmo", tmo_cnt, 0);
        check("f1_grant_clr", grant_o, 4'b0000);
        check("f1_data_kept", tx_data_o, 8'hA5);

        // Stale done stuck high: watchdog fires, requester 3 moves pointer to 0
        req_valid_i = 4'b1000;
        tick();
        check("to_grant", grant_o, 4'b1000);
        check("to_data", tx_data_o, 8'hD3);
        req_valid_i = 4'b0000;
        n = 0;
        while (!timeout_o && n < TO + 50) begin
            tick();
            n++;
        end
        check("to_latency", n, TO);
        tick();
        check("to_pulse_len", timeout_o, 1'b0);
        check("to_in_gap", busy_o, 1'b1);
        tick();
        check("to_idle", busy_o, 1'b0);
        check("to_grant_clr", grant_o, 4'b0000);
        check("to_count", tmo_cnt, 1);

        // All requesters held: round robin 0,1,2,3,0
        req_valid_i = 4'b1111;
        serve(0, 8'h3C);
        serve(1, 8'h5B);
        serve(2, 8'hA5);
        serve(3, 8'hD3);
        serve(0, 8'h3C);
        req_valid_i = 4'b0000;

        // Reset during WAIT_DONE; flush holds off grants until done is high
        req_valid_i = 4'b0010;
        tick();
        check("rw_grant", grant_o, 4'b0010);
        req_valid_i = 4'b0000;
        tx_done_i   = 1'b0;
        repeat (4) tick();
        check("rw_in_wait_en", tx_en_o, 1'b0);
        check("rw_in_wait_busy", busy_o, 1'b1);
        rst_i       = 1'b1;
        req_valid_i = 4'b0001;
        tick();
        check("rw_rst_en", tx_en_o, 1'b0);
        check("rw_rst_grant", grant_o, 4'b0000);
        check("rw_rst_busy", busy_o, 1'b1);
        check("rw_rst_data", tx_data_o, 8'h00);
        rst_i = 1'b0;
        repeat (5) begin
            tick();
            check("rw_flush_nogrant", grant_o, 4'b0000);
            check("rw_flush_busy", busy_o, 1'b1);
        end
        tx_done_i = 1'b1;
        tick();
        check("rw_flush_exit", busy_o, 1'b0);
        serve(0, 8'h3C);
        req_valid_i = 4'b0000;

        // Power-up with done low: flush waits the full watchdog, silently
        rst_i     = 1'b1;
        tx_done_i = 1'b0;
        tick();
        rst_i = 1'b0;
        n = 0;
        while (busy_o && n < TO + 50) begin
            tick();
            n++;
        end
        check("pu_flush_len", n, TO);
        check("pu_no_tmo", tmo_cnt, 1);
        req_valid_i = 4'b0100;
        serve(2, 8'hA5);
        req_valid_i = 4'b0000;

        check("ready_cnt0", ready_cnt[0], 3);
        check("ready_cnt1", ready_cnt[1], 2);
        check("ready_cnt2", ready_cnt[2], 3);
        check("ready_cnt3", ready_cnt[3], 2);
        check("final_tmo", tmo_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
